// File: rtl/wifi_tx_fifo_write_ctrl_if.sv
// rtl/wifi_tx_fifo_write_ctrl_if.sv - TX FIFO write controller source/FIFO/status bundle
interface wifi_tx_fifo_write_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 32
);
    logic                    start;
    logic                    abort;
    logic [SIZE_WIDTH-1:0]   data_size;
    logic                    src_valid;
    logic [DATA_WIDTH-1:0]   src_data;
    logic                    src_ready;
    logic                    W_Full;
    logic                    W_inc;
    logic [DATA_WIDTH-1:0]   W_Data;
    logic                    busy;
    logic                    tx_irq;
    logic                    stall_err;
    logic [SIZE_WIDTH-6:0]   words_written;

    // register/DMA side plus FIFO full flag
    modport master (
        output start, abort, data_size, src_valid, src_data, W_Full,
        input  src_ready, W_inc, W_Data, busy, tx_irq, stall_err, words_written
    );

    // write controller side
    modport slave (
        input  start, abort, data_size, src_valid, src_data, W_Full,
        output src_ready, W_inc, W_Data, busy, tx_irq, stall_err, words_written
    );
endinterface

// File: rtl/wifi_tx_fifo_write_ctrl.sv
// rtl/wifi_tx_fifo_write_ctrl.sv - sequences one TX frame into the async TX FIFO write port
module wifi_tx_fifo_write_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 32,
    parameter int STALL_LIMIT = 1024,
    parameter int STALL_CNT_W = 11
) (
    input  logic                        W_CLK,
    input  logic                        W_rst_n,
    wifi_tx_fifo_write_ctrl_if.slave    bus
);
    // one extra bit over words_written so an all-ones bit length rounds up without wrapping
    localparam int WCNT_W = SIZE_WIDTH - 4;

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    state_t                  state_q, state_d;
    logic [WCNT_W-1:0]       words_total_q, words_total_d;
    logic [SIZE_WIDTH-6:0]   words_written_q, words_written_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                    tx_irq_q, tx_irq_d;
    logic                    stall_err_q, stall_err_d;
    logic                    busy_q, busy_d;

    logic [SIZE_WIDTH:0]     size_round;
    logic [WCNT_W-1:0]       words_req;
    logic                    in_write;
    logic                    ready;
    logic                    fire;
    logic                    stalled;
    logic                    last_word;
    logic [DATA_WIDTH-1:0]   w_data;

    assign size_round = {1'b0, bus.data_size} + (SIZE_WIDTH+1)'(31);
    assign words_req  = WCNT_W'(size_round >> 5);

    // abort wins over both the write and the stall accounting
    assign in_write  = (state_q == WRITE);
    assign ready     = in_write && !bus.W_Full && !bus.abort;
    assign fire      = ready && bus.src_valid;
    assign stalled   = in_write && bus.src_valid && bus.W_Full && !bus.abort;
    assign last_word = ({1'b0, words_written_q} == (words_total_q - 1'b1));
    assign w_data    = in_write ? bus.src_data : '0;

    assign bus.src_ready     = ready;
    assign bus.W_inc         = fire;
    assign bus.W_Data        = w_data;
    assign bus.busy          = busy_q;
    assign bus.tx_irq        = tx_irq_q;
    assign bus.stall_err     = stall_err_q;
    assign bus.words_written = words_written_q;

    // next-state, word/stall counters and the registered status pulses
    always_comb begin
        state_d         = state_q;
        words_total_d   = words_total_q;
        words_written_d = words_written_q;
        stall_cnt_d     = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    words_total_d   = words_req;
                    words_written_d = '0;
                    stall_cnt_d     = '0;
                    state_d         = (words_req == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (fire) begin
                    words_written_d = words_written_q + 1'b1;
                    stall_cnt_d     = '0;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end else if (stalled) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_d == STALL_CNT_W'(STALL_LIMIT)) begin
                        state_d = ERR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_irq_d    = (state_d == DONE);
        stall_err_d = (state_d == ERR);
        busy_d      = (state_d != IDLE);
    end

    // state and counter registers; reset discards any frame in flight
    always_ff @(posedge W_CLK or negedge W_rst_n) begin
        if (!W_rst_n) begin
            state_q         <= IDLE;
            words_total_q   <= '0;
            words_written_q <= '0;
            stall_cnt_q     <= '0;
            tx_irq_q        <= 1'b0;
            stall_err_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            words_total_q   <= words_total_d;
            words_written_q <= words_written_d;
            stall_cnt_q     <= stall_cnt_d;
            tx_irq_q        <= tx_irq_d;
            stall_err_q     <= stall_err_d;
            busy_q          <= busy_d;
        end
    end
endmodule
